cache_refill_mem: RTL
=====================

Name: cache_refill_mem

Overview:
- Main-memory responder on the far side of the cache's miss path.
- Accepts one block request at a time from the cache controller: either a refill read or a write-back of an evicted 32-byte block.
- Read requests return the block as a stream of bytes over successive cycles, which the cache captures through its byte-wide block-fill input.
- `busy` drives the cache stall logic while a transaction is in flight.

Parameters:
- IDX_W, 4, block-index width; memory holds 2**IDX_W blocks of 32 bytes.
- LATENCY, 3, wait cycles between request acceptance and first data beat or write commit; 0 legal, max 15.
- INIT_PATTERN, 1, 1 = at time zero the byte at byte address a holds a[7:0]; 0 = all bytes zero. Reset never clears memory.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-low; 0 resets control state.
- req_valid  input  1  request present.
- req_ready  output  1  high only in IDLE.
- req_addr  input  32  byte address; block index = req_addr[5+IDX_W-1:5], offset = req_addr[4:0]; upper bits ignored (aliasing wraps).
- req_write  input  1  1 = write-back, 0 = refill read.
- req_wdata  input  256  write-back block; byte k = req_wdata[8k+7:8k].
- rsp_valid  output  1  data beat valid.
- rsp_byte  output  8  data byte.
- rsp_offset  output  5  byte offset within block of rsp_byte.
- rsp_last  output  1  final beat of block.
- wb_done  output  1  one-cycle pulse after write-back commit.
- busy  output  1  high in any state except IDLE (stall to cache).

Behaviour:
- Reset (reset=0, async): state IDLE; counters 0; rsp_valid, rsp_byte, rsp_offset, rsp_last, wb_done, busy = 0; req_ready = 1 once in IDLE.
- Reset mid-transaction aborts it:
  - no further beats are produced;
  - a pending write-back is discarded and memory is unchanged.
- All outputs are registered.
- Handshake: the request is accepted on an edge with req_valid=1 and req_ready=1. On acceptance, req_addr, req_write and req_wdata are latched. Inputs are ignored at all other times.
- No backpressure on the response. The cache must sink one beat per cycle.
- FSM states:
  - IDLE -> WAIT on accept with LATENCY>0.
  - IDLE -> STREAM (read) or WRITE (write) on accept with LATENCY=0.
  - WAIT: counts LATENCY cycles, then -> STREAM (read) or WRITE (write).
  - STREAM: 32 cycles, one beat per cycle; -> IDLE after the beat with rsp_last.
  - WRITE: commits all 32 bytes in one edge; wb_done=1 for the following cycle; -> IDLE.
- Timing:
  - Accept at edge N.
  - First beat is visible during the cycle after edge N+1+LATENCY.
  - Beats are consecutive; rsp_offset runs 0..31 in order; rsp_last=1 only with offset 31.
  - Read total busy time: LATENCY+32 cycles.
  - Write total busy time: LATENCY+1 cycles, with wb_done coincident with the return to IDLE.
- Outputs outside STREAM: rsp_valid=0; rsp_byte and rsp_offset hold 0.
- Back-to-back requests:
  - The next request is accepted on the first IDLE edge; no overlap.
  - A read issued after a write-back to the same block returns the written data.
- The counter for offset wraps naturally in 5 bits; the stream ends on the 32nd beat regardless of start offset.

Optional Feature:
- Macro CRITICAL_BYTE_FIRST_EN.
- When defined:
  - STREAM begins at offset req_addr[4:0] and proceeds upward modulo 32, e.g. start 30 gives 30,31,0,...,29.
  - rsp_last is asserted on the 32nd beat, whose offset is start-1 mod 32.
- When undefined: the stream always starts at offset 0 and req_addr[4:0] is ignored.

Test Plan:
- Reset behaviour: hold reset=0 for 3 cycles, release, INIT_PATTERN=1 -> busy=0, req_ready=1, rsp_valid=0.
- Basic read: read req_addr=0x00000040, LATENCY=3 -> busy=1; after 4 edges, 32 beats with rsp_byte 0x40..0x5F and offsets 0..31; rsp_last only on offset 31; then busy=0.
- Write-back then read: write req_addr=0x60 with req_wdata byte k = 0xA0+k -> wb_done pulse 4 cycles after accept. A following read of 0x60 returns 0xA0..0xBF.
- Mid-transaction reset: assert reset during beat 10 of a read -> rsp_valid=0 immediately. A subsequent read of the same block starts again from offset 0.
- Ignored request and aliasing: req_valid held high during STREAM -> no second accept until IDLE. Read of 0x440 with IDX_W=4 aliases block 2 and returns 0x40..0x5F.
- CRITICAL_BYTE_FIRST_EN defined: read 0x0000005E -> offsets 30,31,0..29, bytes 0x5E,0x5F,0x40..0x5D; rsp_last with offset 29.

Source files
------------

// File: rtl/cache_refill_mem_if.sv
// Request/response bundle between the cache miss path (master) and the
// main-memory block responder (slave).
interface cache_refill_mem_if;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic         req_write;
    logic [255:0] req_wdata;
    logic         rsp_valid;
    logic [7:0]   rsp_byte;
    logic [4:0]   rsp_offset;
    logic         rsp_last;
    logic         wb_done;
    logic         busy;

    modport master (
        output req_valid, req_addr, req_write, req_wdata,
        input  req_ready, rsp_valid, rsp_byte, rsp_offset, rsp_last, wb_done, busy
    );

    modport slave (
        input  req_valid, req_addr, req_write, req_wdata,
        output req_ready, rsp_valid, rsp_byte, rsp_offset, rsp_last, wb_done, busy
    );
endinterface

// File: rtl/cache_refill_mem.sv
// Main-memory responder: one 32-byte block refill (byte stream) or write-back at a time.
// Define CRITICAL_BYTE_FIRST_EN to start the refill stream at the requested byte offset.
module cache_refill_mem #(
    parameter int unsigned IDX_W        = 4,
    parameter int unsigned LATENCY      = 3,
    parameter int unsigned INIT_PATTERN = 1
) (
    input logic               clk,
    input logic               reset,
    cache_refill_mem_if.slave bus
);
    localparam int unsigned NBLK      = 1 << IDX_W;
    localparam logic [3:0]  WAIT_LAST = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, STREAM, WRITE} state_t;
    typedef logic [NBLK-1:0][255:0] memImage_t;

    function automatic logic [NBLK*256-1:0] initImage();
        logic [NBLK*256-1:0] img;
        img = '0;
        if (INIT_PATTERN != 0) begin
            for (int unsigned a = 0; a < NBLK * 32; a++) begin
                img[8*a +: 8] = 8'(a);
            end
        end
        return img;
    endfunction

    // Contents exist from time zero and survive reset.
    memImage_t mem = initImage();

    state_t             state, nextState;
    logic [3:0]         waitCnt, nWaitCnt;
    logic [4:0]         beatCnt, nBeatCnt;
    logic [4:0]         offCnt, nOffCnt;
    logic [IDX_W-1:0]   blkIdx;
    logic               writeQ;
    logic [255:0]       wdataQ;
    logic               rspValidQ, nRspValid;
    logic [7:0]         rspByteQ, nRspByte;
    logic [4:0]         rspOffsetQ, nRspOffset;
    logic               rspLastQ, nRspLast;
    logic               wbDoneQ, nWbDone;
    logic               busyQ, readyQ;
    logic               accept, memWe;
    logic [4:0]         startOff;
    logic               unusedAddrBits;

    assign accept = (state == IDLE) && bus.req_valid;
    assign memWe  = (state == WRITE);
    assign unusedAddrBits = ^{bus.req_addr[31:5+IDX_W], bus.req_addr[4:0]};

`ifdef CRITICAL_BYTE_FIRST_EN
    assign startOff = bus.req_addr[4:0];
`else
    assign startOff = '0;
`endif

    always_comb begin
        nextState  = state;
        nWaitCnt   = waitCnt;
        nBeatCnt   = beatCnt;
        nOffCnt    = offCnt;
        nRspValid  = 1'b0;
        nRspByte   = '0;
        nRspOffset = '0;
        nRspLast   = 1'b0;
        nWbDone    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    nWaitCnt = '0;
                    nBeatCnt = '0;
                    nOffCnt  = startOff;
                    if (LATENCY == 0) nextState = bus.req_write ? WRITE : STREAM;
                    else              nextState = WAIT;
                end
            end
            WAIT: begin
                if (waitCnt == WAIT_LAST) nextState = writeQ ? WRITE : STREAM;
                else                      nWaitCnt  = waitCnt + 4'd1;
            end
            STREAM: begin
                // Beat count, not offset, ends the stream so any start offset yields 32 beats.
                nRspValid  = 1'b1;
                nRspByte   = mem[blkIdx][{offCnt, 3'b000} +: 8];
                nRspOffset = offCnt;
                nRspLast   = (beatCnt == 5'd31);
                nOffCnt    = offCnt + 5'd1;
                nBeatCnt   = beatCnt + 5'd1;
                if (beatCnt == 5'd31) nextState = IDLE;
            end
            WRITE: begin
                nWbDone   = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            waitCnt    <= '0;
            beatCnt    <= '0;
            offCnt     <= '0;
            rspValidQ  <= 1'b0;
            rspByteQ   <= '0;
            rspOffsetQ <= '0;
            rspLastQ   <= 1'b0;
            wbDoneQ    <= 1'b0;
            busyQ      <= 1'b0;
            readyQ     <= 1'b1;
        end else begin
            state      <= nextState;
            waitCnt    <= nWaitCnt;
            beatCnt    <= nBeatCnt;
            offCnt     <= nOffCnt;
            rspValidQ  <= nRspValid;
            rspByteQ   <= nRspByte;
            rspOffsetQ <= nRspOffset;
            rspLastQ   <= nRspLast;
            wbDoneQ    <= nWbDone;
            busyQ      <= (nextState != IDLE);
            readyQ     <= (nextState == IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            blkIdx <= bus.req_addr[5+IDX_W-1:5];
            writeQ <= bus.req_write;
            wdataQ <= bus.req_wdata;
        end
    end

    // Gated by reset so an aborted write-back never reaches memory.
    always_ff @(posedge clk) begin
        if (memWe && reset) mem[blkIdx] <= wdataQ;
    end

    assign bus.req_ready  = readyQ;
    assign bus.rsp_valid  = rspValidQ;
    assign bus.rsp_byte   = rspByteQ;
    assign bus.rsp_offset = rspOffsetQ;
    assign bus.rsp_last   = rspLastQ;
    assign bus.wb_done    = wbDoneQ;
    assign bus.busy       = busyQ;
endmodule
